// File: rtl/vga_scanout_if.sv
// Frame-buffer port, drawing-engine write handshake and VGA pins of vga_scanout_arbiter.
interface vga_scanout_if;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic [14:0] ram_a;
    logic        ram_we;
    logic [11:0] ram_wd;
    logic [11:0] ram_rd;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_start;
    logic        vblank;

    modport master (
        input  wr_req, wr_addr, wr_data, ram_rd,
        output wr_ack, ram_a, ram_we, ram_wd,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, vblank
    );

    modport slave (
        output wr_req, wr_addr, wr_data, ram_rd,
        input  wr_ack, ram_a, ram_we, ram_wd,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, vblank
    );
endinterface

// File: rtl/vga_scanout_arbiter.sv
// 160x120 frame buffer scanout to 640x480@60 VGA, sharing the RAM port with a write arbiter.
// Optional SCANOUT_BORDER_EN: visible edge pixels are forced to white (12'hFFF).
module vga_scanout_arbiter #(
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_scanout_if.master bus
);

    localparam int            PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);

    logic [PW-1:0] phase_q, phase_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic [14:0]   ram_a_q, ram_a_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;

    logic          visible;
    logic          rd_slot;
    logic          border;
    logic          addr_ok;
    logic [6:0]    row;
    logic [7:0]    col;
    logic [14:0]   disp_addr;
    logic          ack;
    logic          we;

    always_comb begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
        h_d     = h_q;
        v_d     = v_q;
        if (phase_q == PH_LAST) begin
            if (h_q == 10'd799) begin
                h_d = '0;
                v_d = (v_q == 10'd524) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    assign visible   = (h_q < 10'd640) && (v_q < 10'd480);
    assign rd_slot   = (phase_q == '0) && visible;
    assign row       = v_q[8:2];
    assign col       = h_q[9:2];
    // row*160 as row*128 + row*32
    assign disp_addr = {1'b0, row, 7'b0} + {3'b0, row, 5'b0} + {7'b0, col};
    assign addr_ok   = bus.wr_addr < 15'd19200;

    always_comb begin
        ack     = 1'b0;
        we      = 1'b0;
        ram_a_d = ram_a_q;
        if (!rst_n) begin
            ram_a_d = '0;
        end else if (rd_slot) begin
            ram_a_d = disp_addr;
        end else if (bus.wr_req) begin
            ram_a_d = bus.wr_addr;
            ack     = 1'b1;
            we      = addr_ok;
        end
    end

`ifdef SCANOUT_BORDER_EN
    assign border = (h_q == 10'd0) || (h_q == 10'd639) ||
                    (v_q == 10'd0) || (v_q == 10'd479);
`else
    assign border = 1'b0;
`endif

    // ram_rd for this pixel's read slot is valid during phase 1
    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (phase_q == PH_ONE) begin
            rgb_d = !visible ? 12'h000 : (border ? 12'hFFF : bus.ram_rd);
            hs_d  = !((h_q >= 10'd656) && (h_q <= 10'd751));
            vs_d  = !((v_q >= 10'd490) && (v_q <= 10'd491));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
            h_q     <= '0;
            v_q     <= '0;
            ram_a_q <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            phase_q <= phase_d;
            h_q     <= h_d;
            v_q     <= v_d;
            ram_a_q <= ram_a_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign bus.wr_ack      = ack;
    assign bus.ram_we      = we;
    assign bus.ram_a       = ram_a_d;
    assign bus.ram_wd      = bus.wr_data;
    assign bus.vga_r       = rgb_q[11:8];
    assign bus.vga_g       = rgb_q[7:4];
    assign bus.vga_b       = rgb_q[3:0];
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.frame_start = rst_n && (phase_q == '0) && (h_q == '0) && (v_q == '0);
    assign bus.vblank      = v_q >= 10'd480;

endmodule

// File: tb/tb_vga_scanout_arbiter.sv
// Randomized self-checking bench for vga_scanout_arbiter against a cycle-index timing model.
module tb_vga_scanout_arbiter;

    localparam int CD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_scanout_if vif();

    vga_scanout_arbiter #(.CLK_DIV(CD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    logic [11:0] mem  [0:32767];
    logic [11:0] gold [0:32767];
    logic        loaded = 1'b0;
    int          cyc    = 0;
    logic [14:0] last_a = '0;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          wq[$];

    function automatic int t_h(int t);
        return (t / CD) % 800;
    endfunction

    function automatic int t_v(int t);
        return (t / (CD * 800)) % 525;
    endfunction

    function automatic bit read_slot(int t);
        return (t % CD == 0) && (t_h(t) < 640) && (t_v(t) < 480);
    endfunction

    function automatic int disp_addr(int t);
        return (t_v(t) / 4) * 160 + t_h(t) / 4;
    endfunction

    function automatic logic [14:0] exp_a(int t, logic req, logic [14:0] a, logic [14:0] last);
        if (read_slot(t)) return 15'(disp_addr(t));
        if (req) return a;
        return last;
    endfunction

    function automatic logic [11:0] exp_rgb(int t);
        int h;
        int v;
        if (t < 2) return 12'h000;
        h = t_h(t - 2);
        v = t_v(t - 2);
        if (h >= 640 || v >= 480) return 12'h000;
`ifdef SCANOUT_BORDER_EN
        if (h == 0 || h == 639 || v == 0 || v == 479) return 12'hFFF;
`endif
        return gold[(v / 4) * 160 + h / 4];
    endfunction

    function automatic logic exp_hs(int t);
        int h;
        if (t < 2) return 1'b1;
        h = t_h(t - 2);
        return !(h >= 656 && h <= 751);
    endfunction

    function automatic logic exp_vs(int t);
        int v;
        if (t < 2) return 1'b1;
        v = t_v(t - 2);
        return !(v >= 490 && v <= 491);
    endfunction

    // Frame buffer: synchronous read, data valid the clock after the address.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32768; i++) mem[i] <= gold[i];
            loaded <= 1'b1;
        end else if (vif.ram_we) begin
            mem[vif.ram_a] <= vif.ram_wd;
        end
        vif.ram_rd <= mem[vif.ram_a];
    end

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    always @(posedge clk)
        last_a <= !rst_n ? 15'd0 : exp_a(cyc, vif.wr_req, vif.wr_addr, last_a);

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vif.wr_req  = 1'b1;
        vif.wr_addr = 15'd50;
        vif.wr_data = 12'h123;
        #1;
        n_chk++;
        if ({vif.wr_ack, vif.ram_we, vif.ram_a, vif.frame_start} !== {1'b0, 1'b0, 15'd0, 1'b0})
            $display("FAIL reset_arb ack=%b we=%b a=%0d fs=%b want 0 0 0 0",
                     vif.wr_ack, vif.ram_we, vif.ram_a, vif.frame_start);
        else n_pass++;
        n_chk++;
        if ({vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_hs, vif.vga_vs, vif.vblank} !== {12'h000, 3'b110})
            $display("FAIL reset_video rgb=%h hs=%b vs=%b vb=%b want 000 1 1 0",
                     {vif.vga_r, vif.vga_g, vif.vga_b}, vif.vga_hs, vif.vga_vs, vif.vblank);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        vif.wr_req = 1'b0;
        #1;
        n_chk++;
        if ({vif.frame_start, vif.wr_ack, vif.ram_a} !== {1'b1, 1'b0, 15'd0})
            $display("FAIL reset_release fs=%b ack=%b a=%0d want 1 0 0",
                     vif.frame_start, vif.wr_ack, vif.ram_a);
        else n_pass++;
    endtask

    task automatic test_scan(int n, bit wr_en);
        bit          acked = 1'b0;
        int          t;
        int          tp;
        logic        e_ack;
        logic [14:0] ea;
        logic [15:0] ev;
        logic [15:0] gv;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (acked) vif.wr_req = 1'b0;
            acked = 1'b0;
            if (wr_en && !vif.wr_req && i < n - 8 && $urandom_range(1, 0) == 1) begin
                vif.wr_req  = 1'b1;
                vif.wr_addr = ($urandom_range(7, 0) == 0) ? 15'($urandom_range(32767, 19200))
                                                          : 15'($urandom_range(19199, 2000));
                vif.wr_data = 12'($urandom);
            end
            #1;
            t  = cyc;
            ev = {exp_rgb(t), exp_hs(t), exp_vs(t), 1'b0,
                  (t % CD == 0) && t_h(t) == 0 && t_v(t) == 0};
            gv = {vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_hs, vif.vga_vs, vif.vblank, vif.frame_start};
            n_chk++;
            if (gv !== ev) $display("FAIL scan_video t=%0d got=%h want=%h", t, gv, ev);
            else n_pass++;
            e_ack = vif.wr_req && !read_slot(t);
            ea    = exp_a(t, vif.wr_req, vif.wr_addr, last_a);
            n_chk++;
            if ({vif.wr_ack, vif.ram_we, vif.ram_a, vif.ram_wd} !==
                {e_ack, e_ack && (vif.wr_addr < 15'd19200), ea, vif.wr_data})
                $display("FAIL scan_arb t=%0d ack=%b we=%b a=%0d wd=%h want ack=%b a=%0d",
                         t, vif.wr_ack, vif.ram_we, vif.ram_a, vif.ram_wd, e_ack, ea);
            else n_pass++;
            tp = t - 2;
            if (t >= 2 && tp % CD == 0) begin
                if (t_h(tp) == 2 && t_v(tp) == 2) begin
                    n_chk++;
                    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 12'hF00)
                        $display("FAIL pix_2_2 got=%h want=f00", {vif.vga_r, vif.vga_g, vif.vga_b});
                    else n_pass++;
                end
                if (t_h(tp) == 5 && t_v(tp) == 5) begin
                    n_chk++;
                    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 12'h0F0)
                        $display("FAIL pix_5_5 got=%h want=0f0", {vif.vga_r, vif.vga_g, vif.vga_b});
                    else n_pass++;
                end
                if (t_h(tp) == 640 && t_v(tp) == 0) begin
                    n_chk++;
                    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 12'h000)
                        $display("FAIL pix_640 got=%h want=000", {vif.vga_r, vif.vga_g, vif.vga_b});
                    else n_pass++;
                end
            end
            if (e_ack) begin
                if (vif.wr_addr < 15'd19200) gold[vif.wr_addr] = vif.wr_data;
                wq.push_back(int'(vif.wr_addr));
                acked = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        vif.wr_req = 1'b0;
        @(posedge clk);
        #2;
        foreach (wq[k]) begin
            n_chk++;
            if (mem[wq[k]] !== gold[wq[k]])
                $display("FAIL scan_mem addr=%0d got=%h want=%h", wq[k], mem[wq[k]], gold[wq[k]]);
            else n_pass++;
        end
        wq.delete();
    endtask

    task automatic test_slot_conflict();
        bit found = 1'b0;
        int t0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            found = read_slot(cyc);
        end
        if (!found) begin
            n_chk++;
            $display("FAIL slot_wait no read slot got=timeout want=slot");
            return;
        end
        vif.wr_req  = 1'b1;
        vif.wr_addr = 15'd100;
        vif.wr_data = 12'hABC;
        #1;
        t0 = cyc;
        n_chk++;
        if ({vif.wr_ack, vif.ram_we, vif.ram_a} !== {1'b0, 1'b0, 15'(disp_addr(t0))})
            $display("FAIL slot_read ack=%b we=%b a=%0d want 0 0 %0d",
                     vif.wr_ack, vif.ram_we, vif.ram_a, disp_addr(t0));
        else n_pass++;
        @(posedge clk);
        #2;
        n_chk++;
        if ({vif.wr_ack, vif.ram_we, vif.ram_a, vif.ram_wd} !== {1'b1, 1'b1, 15'd100, 12'hABC})
            $display("FAIL slot_write ack=%b we=%b a=%0d wd=%h want 1 1 100 abc",
                     vif.wr_ack, vif.ram_we, vif.ram_a, vif.ram_wd);
        else n_pass++;
        gold[100] = 12'hABC;
        @(posedge clk);
        #1;
        vif.wr_req = 1'b0;
        #1;
        n_chk++;
        if ({vif.vga_r, vif.vga_g, vif.vga_b} !== exp_rgb(cyc))
            $display("FAIL slot_pixel got=%h want=%h", {vif.vga_r, vif.vga_g, vif.vga_b}, exp_rgb(cyc));
        else n_pass++;
        n_chk++;
        if (mem[100] !== 12'hABC) $display("FAIL slot_mem got=%h want=abc", mem[100]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit          found = 1'b0;
        logic [14:0] a;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (t_h(cyc) == 650) && (cyc % CD == 0);
        end
        if (!found) begin
            n_chk++;
            $display("FAIL b2b_wait got=timeout want=h650");
            return;
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            a           = 15'(5000 + k * 7);
            vif.wr_req  = 1'b1;
            vif.wr_addr = a;
            vif.wr_data = 12'($urandom);
            #1;
            n_chk++;
            if ({vif.wr_ack, vif.ram_we, vif.ram_a} !== {1'b1, 1'b1, a})
                $display("FAIL b2b_ack k=%0d ack=%b we=%b a=%0d want 1 1 %0d",
                         k, vif.wr_ack, vif.ram_we, vif.ram_a, a);
            else n_pass++;
            gold[a] = vif.wr_data;
            wq.push_back(int'(a));
        end
        @(posedge clk);
        #1;
        vif.wr_req  = 1'b1;
        vif.wr_addr = 15'd19200;
        vif.wr_data = 12'hEEE;
        #1;
        n_chk++;
        if ({vif.wr_ack, vif.ram_we} !== 2'b10)
            $display("FAIL drop_ack ack=%b we=%b want 1 0", vif.wr_ack, vif.ram_we);
        else n_pass++;
        @(posedge clk);
        #1;
        vif.wr_req = 1'b0;
        @(posedge clk);
        #2;
        n_chk++;
        if (mem[19200] !== 12'h5A5) $display("FAIL drop_mem got=%h want=5a5", mem[19200]);
        else n_pass++;
        foreach (wq[k]) begin
            n_chk++;
            if (mem[wq[k]] !== gold[wq[k]])
                $display("FAIL b2b_mem addr=%0d got=%h want=%h", wq[k], mem[wq[k]], gold[wq[k]]);
            else n_pass++;
        end
        wq.delete();
    endtask

    task automatic test_midline_reset();
        bit found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (t_h(cyc) == 300) && (t_v(cyc) >= 1) && (cyc % CD == 0);
        end
        if (!found) begin
            n_chk++;
            $display("FAIL mid_wait got=timeout want=h300");
            return;
        end
        rst_n       = 1'b0;
        vif.wr_req  = 1'b1;
        vif.wr_addr = 15'd3000;
        vif.wr_data = 12'h555;
        #1;
        n_chk++;
        if ({vif.wr_ack, vif.ram_we, vif.ram_a, vif.frame_start} !== {1'b0, 1'b0, 15'd0, 1'b0})
            $display("FAIL mid_inflight ack=%b we=%b a=%0d fs=%b want 0 0 0 0",
                     vif.wr_ack, vif.ram_we, vif.ram_a, vif.frame_start);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        vif.wr_req = 1'b0;
        #1;
        n_chk++;
        if ({vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_hs, vif.vga_vs, vif.frame_start, vif.ram_a} !==
            {12'h000, 3'b111, 15'd0})
            $display("FAIL mid_restart rgb=%h hs=%b vs=%b fs=%b a=%0d want 000 1 1 1 0",
                     {vif.vga_r, vif.vga_g, vif.vga_b}, vif.vga_hs, vif.vga_vs,
                     vif.frame_start, vif.ram_a);
        else n_pass++;
        n_chk++;
        if (mem[3000] !== gold[3000])
            $display("FAIL mid_mem got=%h want=%h", mem[3000], gold[3000]);
        else n_pass++;
    endtask

    initial begin
        vif.wr_req  = 1'b0;
        vif.wr_addr = '0;
        vif.wr_data = '0;
        for (int i = 0; i < 32768; i++) gold[i] = 12'($urandom);
        gold[0]     = 12'hF00;
        gold[161]   = 12'h0F0;
        gold[19200] = 12'h5A5;
        test_reset();
        test_scan(7 * 800 * CD + 500, 1'b1);
        test_slot_conflict();
        test_back_to_back();
        test_midline_reset();
        test_scan(3400, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
